ps2_mouse_init: RTL
===================

// Module: ps2_mouse_init
//
// PURPOSE
//   Host-side bring-up sequencer for the PS/2 mouse used by the QL mouse interface.
//   After reset it drives a PS/2 byte transmitter through reset, sample-rate and
//   enable-reporting commands, and checks every device response. It then asserts
//   stream_en so the downstream 3/4-byte packet decoder may consume rx bytes.
//   Sits between the PS/2 rx/tx byte interfaces and the movement-packet decoder.
//
// PARAMETERS
//   TIMEOUT_CYC  2_000_000  cycles allowed per expected response or tx completion
//   RETRIES      3          failed attempts tolerated before init_fail
//   SAMPLE_RATE  8'd100     value sent after the 0xF3 set-sample-rate command
//
// PORTS
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   tx_data    out  8  command byte for the transmitter; stable while tx_req=1
//   tx_req     out  1  request to send tx_data; held until tx_done
//   tx_done    in   1  1-cycle pulse: transmitter finished the byte incl. device ack bit
//   rx_data    in   8  byte from the PS/2 receiver
//   rx_valid   in   1  1-cycle pulse: rx_data is valid
//   rx_error   in   1  1-cycle pulse: framing or parity error on receive
//   stream_en  out  1  1 = init complete; decoder may use rx bytes
//   wheel      out  1  1 = IntelliMouse ID 0x03 detected (4-byte packets)
//   init_fail  out  1  1 = retries exhausted; sticky until reset
//
// BEHAVIOUR
//   - Reset values: tx_req=0, tx_data=0x00, stream_en=0, wheel=0, init_fail=0,
//     step=0, retry count=0. Reset mid-sequence aborts immediately; no partial
//     byte is reissued.
//   - Command list (step ROM): FF, F3, SAMPLE_RATE, F4.
//   - States: SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, NEXT, DONE, FAIL.
//   - SEND (1 cycle): load tx_data from the ROM, set tx_req=1, then go to WAIT_TX.
//   - WAIT_TX: on tx_done, drop tx_req in the same edge and go to WAIT_ACK.
//   - WAIT_ACK, by rx_data:
//     - 0xFA: after FF go to WAIT_BAT; otherwise go to NEXT.
//     - 0xFE: resend the same step (SEND) and increment the retry count.
//     - Any other byte, or rx_error: restart at step 0 and increment the retry count.
//   - WAIT_BAT: 0xAA goes to WAIT_ID; 0xFC or any other byte is a retry with restart
//     at step 0.
//   - WAIT_ID: 0x00 goes to NEXT; any other byte is a retry with restart at step 0.
//   - NEXT: step+1; go to SEND, or to DONE after the last step.
//   - Timeout: a counter clears on every state entry. When it reaches TIMEOUT_CYC in
//     WAIT_TX, WAIT_ACK, WAIT_BAT or WAIT_ID, the block drops tx_req, increments
//     the retry count and restarts at step 0.
//   - Retry limit: when the retry count exceeds RETRIES, go to FAIL. FAIL sets
//     init_fail=1, keeps stream_en=0 and stays until reset.
//   - DONE: stream_en=1 (registered; first high cycle is the one after NEXT).
//     rx bytes are ignored by this block.
//   - Priority: rx_valid and rx_error in the same cycle count as rx_error.
//     rx_valid outside WAIT_ACK, WAIT_BAT or WAIT_ID is ignored, except in the
//     WAIT_TX case below.
//   - Response before tx_done: an rx_valid in WAIT_TX arriving together with or
//     before tx_done is held in a 1-byte latch and evaluated on entry to WAIT_ACK.
//
// CONFIGURATION
//   PS2_WHEEL_EN defined:
//     - After WAIT_ID the ROM also sends F3 C8 F3 64 F3 50 F2; each byte expects 0xFA.
//     - After F2, WAIT_ID2 captures the next byte: 0x03 sets wheel=1; any other
//       value sets wheel=0. No retry occurs on this byte.
//     - The sequence then continues with F3 SAMPLE_RATE F4.
//   PS2_WHEEL_EN undefined: wheel is tied to 0 and the extra ROM entries and state
//     are not compiled.
//
// TESTING
//   1 Model answers FA; AA; 00; FA; FA; FA -> tx bytes FF,F3,64,F4 in order;
//     stream_en=1 one cycle after last FA; init_fail=0.
//   2 First FF answered FE -> FF resent exactly once; sequence completes;
//     tx count = 5.
//   3 TIMEOUT_CYC=100, RETRIES=3, device silent -> FF sent 4 times;
//     init_fail=1 about 400 cycles after reset; stream_en stays 0.
//   4 BAT returns FC -> restart at FF; second attempt normal -> stream_en=1.
//   5 reset pulse while tx_req=1 during F3 -> next cycle tx_req=0, stream_en=0;
//     sequence restarts with FF.
//   6 (PS2_WHEEL_EN) ID reply 03 after F2 -> wheel=1; reply 00 -> wheel=0;
//     both reach stream_en=1.

Source files
------------

// File: rtl/ps2_mouse_init.sv
// ps2_mouse_init: host-side PS/2 mouse bring-up sequencer.
// Sends FF (reset), F3/rate (sample rate) and F4 (enable reporting) in turn, and
// checks every device reply. It raises stream_en once the device is streaming,
// or init_fail once too many attempts have failed.
// Optional build macro PS2_WHEEL_EN inserts the IntelliMouse knock sequence
// (F3 C8 F3 64 F3 50 F2) and samples the returned device ID into wheel.
module ps2_mouse_init #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned RETRIES     = 3,
    parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       stream_en,
    output logic       wheel,
    output logic       init_fail
);
    localparam logic [3:0] S_SEND     = 4'd0;
    localparam logic [3:0] S_WAIT_TX  = 4'd1;
    localparam logic [3:0] S_WAIT_ACK = 4'd2;
    localparam logic [3:0] S_WAIT_BAT = 4'd3;
    localparam logic [3:0] S_WAIT_ID  = 4'd4;
    localparam logic [3:0] S_NEXT     = 4'd5;
    localparam logic [3:0] S_DONE     = 4'd6;
    localparam logic [3:0] S_FAIL     = 4'd7;
`ifdef PS2_WHEEL_EN
    localparam logic [3:0] S_WAIT_ID2 = 4'd8;
    localparam logic [3:0] LAST_STEP  = 4'd10;
    localparam logic [3:0] ID_STEP    = 4'd7;   // step that sends F2 (read ID)
`else
    localparam logic [3:0] LAST_STEP  = 4'd3;
`endif

    localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam int RW = $clog2(RETRIES + 2) + 1;

    logic [3:0]    state;
    logic [3:0]    step;
    logic [TW-1:0] tmr;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic          retry_over;
    logic          timeout;
    logic          pend_vld;
    logic          pend_err;
    logic [7:0]    pend_data;
    logic          rsp_vld;
    logic          rsp_err;
    logic [7:0]    rsp_byte;
    logic          resend;
    logic          restart;
`ifdef PS2_WHEEL_EN
    logic          wheel_q;
    assign wheel = wheel_q;
`else
    assign wheel = 1'b0;
`endif

    // Command ROM indexed by step.
    function automatic logic [7:0] rom_byte(input logic [3:0] s);
`ifdef PS2_WHEEL_EN
        case (s)
            4'd0:    rom_byte = 8'hFF;
            4'd1:    rom_byte = 8'hF3;
            4'd2:    rom_byte = 8'hC8;
            4'd3:    rom_byte = 8'hF3;
            4'd4:    rom_byte = 8'h64;
            4'd5:    rom_byte = 8'hF3;
            4'd6:    rom_byte = 8'h50;
            4'd7:    rom_byte = 8'hF2;
            4'd8:    rom_byte = 8'hF3;
            4'd9:    rom_byte = SAMPLE_RATE;
            default: rom_byte = 8'hF4;
        endcase
`else
        case (s)
            4'd0:    rom_byte = 8'hFF;
            4'd1:    rom_byte = 8'hF3;
            4'd2:    rom_byte = SAMPLE_RATE;
            default: rom_byte = 8'hF4;
        endcase
`endif
    endfunction

    assign retry_nxt  = retry_cnt + 1'b1;
    assign retry_over = retry_nxt > RW'(RETRIES);
    assign timeout    = tmr >= TMO_LAST;

    // Effective response: a byte latched during WAIT_TX takes precedence; error beats data.
    always_comb begin
        rsp_vld  = pend_vld | rx_valid | rx_error;
        rsp_err  = pend_vld ? pend_err  : rx_error;
        rsp_byte = pend_vld ? pend_data : rx_data;
    end

    // Classify the current cycle as resend-same-step, restart-from-FF, or neither.
    always_comb begin
        resend  = 1'b0;
        restart = 1'b0;
        case (state)
            S_WAIT_TX:  restart = !tx_done && timeout;
            S_WAIT_ACK: begin
                if (rsp_vld) begin
                    if (rsp_err)                resend = 1'b0;
                    else if (rsp_byte == 8'hFE) resend = 1'b1;
                    restart = rsp_err || (rsp_byte != 8'hFA && rsp_byte != 8'hFE);
                end else begin
                    restart = timeout;
                end
            end
            S_WAIT_BAT: restart = rsp_vld ? (rsp_err || rsp_byte != 8'hAA) : timeout;
            S_WAIT_ID:  restart = rsp_vld ? (rsp_err || rsp_byte != 8'h00) : timeout;
            default:    ;
        endcase
    end

    // Sequencer state, retry bookkeeping, response latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SEND;
            step      <= 4'd0;
            retry_cnt <= '0;
            tmr       <= '0;
            tx_req    <= 1'b0;
            tx_data   <= 8'h00;
            stream_en <= 1'b0;
            init_fail <= 1'b0;
            pend_vld  <= 1'b0;
            pend_err  <= 1'b0;
            pend_data <= 8'h00;
`ifdef PS2_WHEEL_EN
            wheel_q   <= 1'b0;
`endif
        end else begin
            if (tmr != '1) tmr <= tmr + 1'b1;
            if (state != S_WAIT_TX) pend_vld <= 1'b0;
            if (resend || restart) begin
                tx_req    <= 1'b0;
                tmr       <= '0;
                retry_cnt <= retry_nxt;
                if (retry_over) begin
                    state     <= S_FAIL;
                    init_fail <= 1'b1;
                end else begin
                    state <= S_SEND;
                    if (restart) step <= 4'd0;
                end
            end else begin
                case (state)
                    S_SEND: begin
                        tx_data <= rom_byte(step);
                        tx_req  <= 1'b1;
                        state   <= S_WAIT_TX;
                        tmr     <= '0;
                    end
                    S_WAIT_TX: begin
                        if (rx_valid || rx_error) begin
                            pend_vld  <= 1'b1;
                            pend_err  <= rx_error;
                            pend_data <= rx_data;
                        end
                        if (tx_done) begin
                            tx_req <= 1'b0;
                            state  <= S_WAIT_ACK;
                            tmr    <= '0;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (rsp_vld) begin
                            tmr <= '0;
                            if (step == 4'd0)      state <= S_WAIT_BAT;
`ifdef PS2_WHEEL_EN
                            else if (step == ID_STEP) state <= S_WAIT_ID2;
`endif
                            else                   state <= S_NEXT;
                        end
                    end
                    S_WAIT_BAT: if (rsp_vld) begin state <= S_WAIT_ID; tmr <= '0; end
                    S_WAIT_ID:  if (rsp_vld) begin state <= S_NEXT;    tmr <= '0; end
`ifdef PS2_WHEEL_EN
                    S_WAIT_ID2: begin
                        if (rsp_vld || timeout) begin
                            wheel_q <= rsp_vld && !rsp_err && rsp_byte == 8'h03;
                            state   <= S_NEXT;
                            tmr     <= '0;
                        end
                    end
`endif
                    S_NEXT: begin
                        tmr <= '0;
                        if (step == LAST_STEP) begin
                            state     <= S_DONE;
                            stream_en <= 1'b1;
                        end else begin
                            step  <= step + 1'b1;
                            state <= S_SEND;
                        end
                    end
                    S_DONE:  ;
                    S_FAIL:  ;
                    default: begin
                        state <= S_SEND;
                        tmr   <= '0;
                    end
                endcase
            end
        end
    end
endmodule
